// File: rtl/adbg_or1k_burst_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : adbg_or1k_burst_ctrl
//  Purpose  : OR1K debug command sequencer (CPU clock domain). Executes
//             32-bit burst reads/writes on the CPU debug bus, streams data to
//             and from the JTAG side, and owns the stall/reset status register.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module adbg_or1k_burst_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int CORE_WIDTH = 4
) (
   input  logic                  cpu_clk_i,
   input  logic                  cpu_rst_i,
   // command channel
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [3:0]            cmd_op_i,
   input  logic [CORE_WIDTH-1:0] cmd_core_i,
   input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
   input  logic [CNT_WIDTH-1:0]  cmd_cnt_i,
   input  logic [1:0]            cmd_status_i,
   // write-data stream from JTAG side
   input  logic                  wdat_valid_i,
   output logic                  wdat_ready_o,
   input  logic [DATA_WIDTH-1:0] wdat_i,
   // read-data stream to JTAG side
   output logic                  rdat_valid_o,
   input  logic                  rdat_ready_i,
   output logic [DATA_WIDTH-1:0] rdat_o,
   // CPU debug bus
   output logic                  cpu_stb_o,
   output logic                  cpu_we_o,
   output logic [ADDR_WIDTH-1:0] cpu_adr_o,
   output logic [DATA_WIDTH-1:0] cpu_dat_o,
   output logic [CORE_WIDTH-1:0] cpu_core_o,
   input  logic [DATA_WIDTH-1:0] cpu_dat_i,
   input  logic                  cpu_ack_i,
   input  logic                  cpu_bp_i,
   // CPU control and status
   output logic                  cpu_stall_o,
   output logic                  cpu_rst_o,
   output logic                  busy_o,
   output logic                  err_o
);

   // Sequencer states
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_WAIT = 3'd1;
   localparam logic [2:0] ST_WR_ACC  = 3'd2;
   localparam logic [2:0] ST_RD_ACC  = 3'd3;
   localparam logic [2:0] ST_RD_PUSH = 3'd4;

   // Command opcodes
   localparam logic [3:0] OP_NOP      = 4'h0;
   localparam logic [3:0] OP_BWRITE32 = 4'h3;
   localparam logic [3:0] OP_BREAD32  = 4'h7;
   localparam logic [3:0] OP_IREG_WR  = 4'h9;
   localparam logic [3:0] OP_IREG_SEL = 4'hD;

   localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(4);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = '0;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] adr_q,   adr_d;
   logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
   logic [CORE_WIDTH-1:0] core_q,  core_d;
   logic [DATA_WIDTH-1:0] wdat_q,  wdat_d;
   logic [DATA_WIDTH-1:0] rdat_q,  rdat_d;
   logic                  err_q,   err_d;
   logic                  idx_q,   idx_d;
   logic                  stall_q, stall_d;
   logic                  crst_q,  crst_d;
   logic                  status_wr;

   // Handshake and bus strobes are pure functions of the current state, so
   // they hold steady until the matching ready/ack moves the state on.
   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign wdat_ready_o = (state_q == ST_WR_WAIT);
   assign rdat_valid_o = (state_q == ST_RD_PUSH);
   assign cpu_stb_o    = (state_q == ST_WR_ACC) || (state_q == ST_RD_ACC);
   assign cpu_we_o     = (state_q == ST_WR_ACC);
   assign cpu_adr_o    = adr_q;
   assign cpu_core_o   = core_q;
   assign cpu_dat_o    = wdat_q;
   assign rdat_o       = rdat_q;
   assign err_o        = err_q;
   assign cpu_stall_o  = stall_q;
   assign cpu_rst_o    = crst_q;

   // Next-state logic for the sequencer and its datapath registers
   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      cnt_d     = cnt_q;
      core_d    = core_q;
      wdat_d    = wdat_q;
      rdat_d    = rdat_q;
      err_d     = err_q;
      idx_d     = idx_q;
      status_wr = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               adr_d  = cmd_adr_i;
               cnt_d  = cmd_cnt_i;
               core_d = cmd_core_i;
               err_d  = 1'b0;
               case (cmd_op_i)
                  OP_NOP: begin
                  end
                  OP_BWRITE32: begin
                     // A zero-length burst is flagged rather than run
                     if (cmd_cnt_i == CNT_ZERO) begin
                        err_d = 1'b1;
                     end else begin
                        state_d = ST_WR_WAIT;
                     end
                  end
                  OP_BREAD32: begin
                     if (cmd_cnt_i == CNT_ZERO) begin
                        err_d = 1'b1;
                     end else begin
                        state_d = ST_RD_ACC;
                     end
                  end
                  OP_IREG_SEL: begin
                     // Only register 0 (STATUS) exists
                     idx_d = cmd_adr_i[0];
                     err_d = idx_d;
                  end
                  OP_IREG_WR: begin
                     idx_d = cmd_adr_i[0];
                     if (idx_d) begin
                        err_d = 1'b1;
                     end else begin
                        status_wr = 1'b1;
                     end
                  end
                  default: begin
                     err_d = 1'b1;
                  end
               endcase
            end
         end

         ST_WR_WAIT: begin
            if (wdat_valid_i) begin
               wdat_d  = wdat_i;
               state_d = ST_WR_ACC;
            end
         end

         ST_WR_ACC: begin
            if (cpu_ack_i) begin
               adr_d   = adr_q + ADR_STEP;
               cnt_d   = cnt_q - CNT_ONE;
               state_d = (cnt_q == CNT_ONE) ? ST_IDLE : ST_WR_WAIT;
            end
         end

         ST_RD_ACC: begin
            if (cpu_ack_i) begin
               rdat_d  = cpu_dat_i;
               state_d = ST_RD_PUSH;
            end
         end

         ST_RD_PUSH: begin
            if (rdat_ready_i) begin
               adr_d   = adr_q + ADR_STEP;
               cnt_d   = cnt_q - CNT_ONE;
               state_d = (cnt_q == CNT_ONE) ? ST_IDLE : ST_RD_ACC;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status register: a breakpoint always forces stall, even over a write
   always_comb begin
      stall_d = stall_q;
      crst_d  = crst_q;
      if (status_wr) begin
         stall_d = cmd_status_i[0];
         crst_d  = cmd_status_i[1];
      end
      if (cpu_bp_i) begin
         stall_d = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge cpu_clk_i) begin
      if (cpu_rst_i) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         cnt_q   <= '0;
         core_q  <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         err_q   <= 1'b0;
         idx_q   <= 1'b0;
         stall_q <= 1'b0;
         crst_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         cnt_q   <= cnt_d;
         core_q  <= core_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         stall_q <= stall_d;
         crst_q  <= crst_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adbg_or1k_burst_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : tb_adbg_or1k_burst_ctrl
//  Purpose  : Directed self-checking bench for adbg_or1k_burst_ctrl
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_adbg_or1k_burst_ctrl;

   localparam logic [3:0] OP_NOP      = 4'h0;
   localparam logic [3:0] OP_BWRITE32 = 4'h3;
   localparam logic [3:0] OP_BREAD32  = 4'h7;
   localparam logic [3:0] OP_IREG_WR  = 4'h9;
   localparam logic [3:0] OP_IREG_SEL = 4'hD;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [3:0]  cmd_op;
   logic [3:0]  cmd_core;
   logic [31:0] cmd_adr;
   logic [15:0] cmd_cnt;
   logic [1:0]  cmd_status;
   logic        wdat_valid, wdat_ready;
   logic [31:0] wdat;
   logic        rdat_valid, rdat_ready;
   logic [31:0] rdat;
   logic        cpu_stb, cpu_we;
   logic [31:0] cpu_adr, cpu_dat_o, cpu_dat_i;
   logic [3:0]  cpu_core;
   logic        cpu_ack, cpu_bp;
   logic        cpu_stall, cpu_rst;
   logic        busy, err;

   int          n_vec = 0;
   int          n_err = 0;

   // bus responder / stream source controls
   int          ack_mode;   // 0 never, 1 same cycle, 2 after 2 wait cycles
   int          stb_cnt;
   logic        wsrc_en;
   int          widx;
   logic [31:0] wlist [8];

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  core;
   } acc_t;
   acc_t        acc_q [$];
   logic [31:0] beat_q [$];

   always #5 clk = ~clk;

   adbg_or1k_burst_ctrl #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .CNT_WIDTH  (16),
      .CORE_WIDTH (4)
   ) dut (
      .cpu_clk_i    (clk),
      .cpu_rst_i    (rst),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_op_i     (cmd_op),
      .cmd_core_i   (cmd_core),
      .cmd_adr_i    (cmd_adr),
      .cmd_cnt_i    (cmd_cnt),
      .cmd_status_i (cmd_status),
      .wdat_valid_i (wdat_valid),
      .wdat_ready_o (wdat_ready),
      .wdat_i       (wdat),
      .rdat_valid_o (rdat_valid),
      .rdat_ready_i (rdat_ready),
      .rdat_o       (rdat),
      .cpu_stb_o    (cpu_stb),
      .cpu_we_o     (cpu_we),
      .cpu_adr_o    (cpu_adr),
      .cpu_dat_o    (cpu_dat_o),
      .cpu_core_o   (cpu_core),
      .cpu_dat_i    (cpu_dat_i),
      .cpu_ack_i    (cpu_ack),
      .cpu_bp_i     (cpu_bp),
      .cpu_stall_o  (cpu_stall),
      .cpu_rst_o    (cpu_rst),
      .busy_o       (busy),
      .err_o        (err)
   );

   // Bus slave: read data is the address XOR a fixed pattern
   assign cpu_dat_i = cpu_adr ^ 32'h5A5A_5A5A;
   assign cpu_ack   = (ack_mode == 1) ? cpu_stb :
                      (ack_mode == 2) ? (cpu_stb && (stb_cnt >= 2)) : 1'b0;
   assign wdat_valid = wsrc_en;
   assign wdat       = wlist[widx[2:0]];

   always @(posedge clk) begin
      if (!cpu_stb || cpu_ack) stb_cnt <= 0;
      else                     stb_cnt <= stb_cnt + 1;
      if (rst)                        widx <= 0;
      else if (wdat_valid && wdat_ready) widx <= widx + 1;
   end

   // Transaction logger
   always @(posedge clk) begin
      if (!rst && cpu_stb && cpu_ack)
         acc_q.push_back('{we: cpu_we, adr: cpu_adr,
                           dat: (cpu_we ? cpu_dat_o : cpu_dat_i), core: cpu_core});
      if (!rst && rdat_valid && rdat_ready)
         beat_q.push_back(rdat);
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] core, input logic [31:0] adr,
                       input logic [15:0] cnt, input logic [1:0] st);
      chk("cmd_ready", {63'd0, cmd_ready}, 64'd1);
      cmd_op     = op;
      cmd_core   = core;
      cmd_adr    = adr;
      cmd_cnt    = cnt;
      cmd_status = st;
      cmd_valid  = 1'b1;
      tick();
      cmd_valid  = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_wa [3];
      logic [31:0] exp_wd [3];
      int n;

      exp_wa = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
      exp_wd = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
      wlist  = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D,
                 32'hE000_000E, 32'hF000_000F, 32'h1111_1111, 32'h2222_2222};
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_core = 4'h0; cmd_adr = 32'h0;
      cmd_cnt = 16'h0; cmd_status = 2'b00; rdat_ready = 1'b0; cpu_bp = 1'b0;
      ack_mode = 0; wsrc_en = 1'b0;

      // ---------------- reset ----------------
      tick(); tick();
      chk("rst_ctl", {58'd0, cmd_ready, busy, err, wdat_ready, rdat_valid, cpu_stb}, 64'h20);
      chk("rst_we_st", {61'd0, cpu_we, cpu_stall, cpu_rst}, 64'h0);
      chk("rst_adr", {32'd0, cpu_adr}, 64'h0);
      chk("rst_dat", {cpu_dat_o, rdat}, 64'h0);
      chk("rst_core", {60'd0, cpu_core}, 64'h0);
      rst = 1'b0;
      tick();

      // ---------------- write burst, zero-wait ----------------
      wsrc_en = 1'b1; ack_mode = 1;
      send(OP_BWRITE32, 4'h5, 32'h0000_1000, 16'd3, 2'b00);
      chk("wr_wdat_rdy", {63'd0, wdat_ready}, 64'd1);
      chk("wr_core", {60'd0, cpu_core}, 64'h5);
      n = 0;
      while (busy && n < 50) begin tick(); n++; end
      chk("wr_busy_cycles", 64'(n), 64'd6);
      chk("wr_idle_rdy", {63'd0, cmd_ready}, 64'd1);
      chk("wr_n", 64'(acc_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < acc_q.size()) begin
            chk("wr_adr", {32'd0, acc_q[i].adr}, {32'd0, exp_wa[i]});
            chk("wr_dat", {32'd0, acc_q[i].dat}, {32'd0, exp_wd[i]});
            chk("wr_we_core", {59'd0, acc_q[i].we, acc_q[i].core}, 64'h15);
         end
      end
      wsrc_en = 1'b0;
      acc_q.delete();

      // ---------------- read burst, wrap, delayed ack, stalled consumer ----------------
      ack_mode = 2; rdat_ready = 1'b0;
      send(OP_BREAD32, 4'h2, 32'hFFFF_FFFC, 16'd2, 2'b00);
      chk("rd_stb_lat", {63'd0, cpu_stb}, 64'd1);
      chk("rd_adr0", {32'd0, cpu_adr}, 64'hFFFF_FFFC);
      n = 0;
      while (!rdat_valid && n < 20) begin tick(); n++; end
      chk("rd_valid0", {63'd0, rdat_valid}, 64'd1);
      chk("rd_dat0", {32'd0, rdat}, 64'hA5A5_A5A6);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rd_hold_v", {63'd0, rdat_valid}, 64'd1);
         chk("rd_hold_d", {32'd0, rdat}, 64'hA5A5_A5A6);
      end
      rdat_ready = 1'b1;
      n = 0;
      while (busy && n < 50) begin tick(); n++; end
      chk("rd_idle", {63'd0, busy}, 64'd0);
      rdat_ready = 1'b0;
      tick(); tick();
      chk("rd_n", 64'(acc_q.size()), 64'd2);
      if (acc_q.size() == 2) begin
         chk("rd_adr_a", {31'd0, acc_q[0].we, acc_q[0].adr}, 64'hFFFF_FFFC);
         chk("rd_adr_b", {31'd0, acc_q[1].we, acc_q[1].adr}, 64'h0000_0000);
      end
      chk("rd_beats", 64'(beat_q.size()), 64'd2);
      if (beat_q.size() == 2) begin
         chk("rd_beat0", {32'd0, beat_q[0]}, 64'hA5A5_A5A6);
         chk("rd_beat1", {32'd0, beat_q[1]}, 64'h5A5A_5A5A);
      end
      acc_q.delete(); beat_q.delete();

      // ---------------- internal status register ----------------
      ack_mode = 0;
      send(OP_IREG_SEL, 4'h0, 32'h0, 16'd0, 2'b00);
      chk("sel0_err", {63'd0, err}, 64'd0);
      send(OP_IREG_WR, 4'h0, 32'h0, 16'd0, 2'b11);
      chk("wr11_st", {62'd0, cpu_rst, cpu_stall}, 64'h3);
      send(OP_IREG_SEL, 4'h0, 32'h1, 16'd0, 2'b00);
      chk("sel1_err", {63'd0, err}, 64'd1);
      send(OP_IREG_WR, 4'h0, 32'h1, 16'd0, 2'b00);
      chk("wr_idx1_err", {63'd0, err}, 64'd1);
      chk("wr_idx1_st", {62'd0, cpu_rst, cpu_stall}, 64'h3);
      cpu_bp = 1'b1;
      send(OP_IREG_WR, 4'h0, 32'h0, 16'd0, 2'b00);
      cpu_bp = 1'b0;
      chk("bp_vs_wr_st", {62'd0, cpu_rst, cpu_stall}, 64'h1);
      chk("bp_vs_wr_err", {63'd0, err}, 64'd0);
      send(OP_IREG_WR, 4'h0, 32'h0, 16'd0, 2'b00);
      chk("wr00_st", {62'd0, cpu_rst, cpu_stall}, 64'h0);
      cpu_bp = 1'b1; tick(); cpu_bp = 1'b0;
      chk("bp_only_st", {62'd0, cpu_rst, cpu_stall}, 64'h1);

      // ---------------- error cases ----------------
      ack_mode = 1;
      send(4'h5, 4'h0, 32'h0, 16'd1, 2'b00);
      chk("rsvd_err", {62'd0, err, busy}, 64'h2);
      send(OP_NOP, 4'h0, 32'h0, 16'd0, 2'b00);
      chk("nop_clr_err", {63'd0, err}, 64'd0);
      send(OP_BREAD32, 4'h0, 32'h2000, 16'd0, 2'b00);
      chk("rd0_err", {61'd0, err, busy, cpu_stb}, 64'h4);
      send(OP_BWRITE32, 4'h0, 32'h2000, 16'd0, 2'b00);
      chk("wr0_err", {61'd0, err, busy, wdat_ready}, 64'h4);
      tick(); tick();
      chk("err_no_bus", 64'(acc_q.size()), 64'd0);
      send(OP_NOP, 4'h0, 32'h0, 16'd0, 2'b00);
      chk("nop2_clr_err", {63'd0, err}, 64'd0);

      // ---------------- reset in the middle of a write burst ----------------
      send(OP_IREG_WR, 4'h0, 32'h0, 16'd0, 2'b11);
      acc_q.delete();
      wsrc_en = 1'b1; ack_mode = 1;
      send(OP_BWRITE32, 4'h1, 32'h0000_3000, 16'd4, 2'b00);
      n = 0;
      while (acc_q.size() < 1 && n < 20) begin tick(); n++; end
      ack_mode = 0;
      n = 0;
      while (!cpu_stb && n < 20) begin tick(); n++; end
      chk("mid_stb2", {63'd0, cpu_stb}, 64'd1);
      chk("mid_adr2", {32'd0, cpu_adr}, 64'h0000_3004);
      rst = 1'b1;
      tick();
      chk("mid_rst_ctl", {61'd0, cpu_stb, busy, cmd_ready}, 64'h1);
      chk("mid_rst_st", {62'd0, cpu_rst, cpu_stall}, 64'h0);
      chk("mid_rst_adr", {32'd0, cpu_adr}, 64'h0);
      rst = 1'b0; ack_mode = 1;
      for (int i = 0; i < 10; i++) tick();
      chk("mid_no_more", 64'(acc_q.size()), 64'd1);
      chk("mid_idle", {63'd0, busy}, 64'd0);
      wsrc_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
